// File: rtl/demux_pkg.sv
// Shared definitions for the demux round-robin scheduler: channel geometry,
// FSM state encoding, mode encoding and a one-hot helper.
package demux_pkg;

    localparam int CH_NUM = 8;
    localparam int CH_W   = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    localparam logic MODE_RR  = 1'b0;
    localparam logic MODE_FIX = 1'b1;

    function automatic logic [CH_NUM-1:0] onehot_ch(input logic [CH_W-1:0] idx);
        return {{(CH_NUM-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/rr_next_finder.sv
// Combinational search for the first set mask bit at or after 'start',
// wrapping from the top channel back to channel 0.
module rr_next_finder
    import demux_pkg::*;
(
    input  logic [CH_NUM-1:0] mask,
    input  logic [CH_W-1:0]   start,
    output logic [CH_W-1:0]   idx,
    output logic              found
);

    // Walk the channels in priority order from 'start'; keep the first hit.
    always_comb begin
        logic [CH_W-1:0] cand;
        cand  = start;
        idx   = start;
        found = 1'b0;
        for (int i = 0; i < CH_NUM; i++) begin
            cand  = start + CH_W'(i);
            idx   = (mask[cand] && !found) ? cand : idx;
            found = found | mask[cand];
        end
    end

endmodule

// File: rtl/demux_rr_scheduler.sv
// Sequencing controller in front of a 1-to-8 demux: accepts one word at a time,
// routes it round-robin or by fixed select, and reroutes stalled round-robin transfers.
module demux_rr_scheduler
    import demux_pkg::*;
#(
    parameter int DW      = 8,
    parameter int TIMEOUT = 15
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic [2:0]        sel,
    input  logic [7:0]        en_mask,
    input  logic              in_valid,
    input  logic [DW-1:0]     in_data,
    output logic              in_ready,
    output logic [7:0]        out_valid,
    output logic [DW-1:0]     out_data,
    input  logic [7:0]        out_ready,
    output logic [2:0]        cur_tgt,
    output logic              busy,
    output logic [15:0]       xfer_cnt,
    output logic [7:0]        reroute_cnt
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_e             state_r, state_s;
    logic [DW-1:0]      data_r, data_s;
    logic [CH_W-1:0]    tgt_r, tgt_s, ptr_r, ptr_s;
    logic [7:0]         wait_r, wait_s;
    logic               mode_r, mode_s, in_ready_r, in_ready_s;
    logic [CH_NUM-1:0]  out_valid_r, out_valid_s;
    logic [15:0]        xfer_r, xfer_s;
    logic [7:0]         reroute_r, reroute_s;
    logic [CH_W-1:0]    acc_idx_s, acc_tgt_s, alt_idx_s, alt_start_s;
    logic               acc_found_s, alt_found_s, idle_ready_s, stuck_s;
    logic [CH_NUM-1:0]  alt_mask_s;

    assign alt_start_s = tgt_r + 3'd1;
    assign alt_mask_s  = en_mask & ~onehot_ch(tgt_r);

    rr_next_finder u_acc_finder (
        .mask  (en_mask),
        .start (ptr_r),
        .idx   (acc_idx_s),
        .found (acc_found_s)
    );

    rr_next_finder u_alt_finder (
        .mask  (alt_mask_s),
        .start (alt_start_s),
        .idx   (alt_idx_s),
        .found (alt_found_s)
    );

    assign idle_ready_s = (mode == MODE_FIX) || (en_mask != 8'h00);
    // A mask that went empty after in_ready was registered parks the word on ptr.
    assign acc_tgt_s    = (mode == MODE_FIX) ? sel : (acc_found_s ? acc_idx_s : ptr_r);
    assign stuck_s      = (wait_r == WAIT_LAST) || !en_mask[tgt_r];

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            data_r      <= '0;
            tgt_r       <= 3'd0;
            ptr_r       <= 3'd0;
            wait_r      <= 8'd0;
            mode_r      <= MODE_RR;
            in_ready_r  <= 1'b0;
            out_valid_r <= 8'h00;
            xfer_r      <= 16'd0;
            reroute_r   <= 8'd0;
        end else begin
            state_r     <= state_s;
            data_r      <= data_s;
            tgt_r       <= tgt_s;
            ptr_r       <= ptr_s;
            wait_r      <= wait_s;
            mode_r      <= mode_s;
            in_ready_r  <= in_ready_s;
            out_valid_r <= out_valid_s;
            xfer_r      <= xfer_s;
            reroute_r   <= reroute_s;
        end
    end

    // Next-state and next-output logic; completion takes priority over rerouting.
    always_comb begin
        state_s     = state_r;
        data_s      = data_r;
        tgt_s       = tgt_r;
        ptr_s       = ptr_r;
        wait_s      = wait_r;
        mode_s      = mode_r;
        in_ready_s  = 1'b0;
        out_valid_s = out_valid_r;
        xfer_s      = xfer_r;
        reroute_s   = reroute_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid && in_ready_r) begin
                    data_s      = in_data;
                    mode_s      = mode;
                    tgt_s       = acc_tgt_s;
                    wait_s      = 8'd0;
                    out_valid_s = onehot_ch(acc_tgt_s);
                    state_s     = ST_SEND;
                end else begin
                    in_ready_s  = idle_ready_s;
                end
            end
            ST_SEND: begin
                if (out_ready[tgt_r]) begin
                    xfer_s      = xfer_r + 16'd1;
                    ptr_s       = (mode_r == MODE_RR) ? alt_start_s : ptr_r;
                    out_valid_s = 8'h00;
                    in_ready_s  = idle_ready_s;
                    state_s     = ST_IDLE;
                end else if ((mode_r == MODE_RR) && stuck_s && alt_found_s) begin
                    tgt_s       = alt_idx_s;
                    wait_s      = 8'd0;
                    out_valid_s = onehot_ch(alt_idx_s);
                    reroute_s   = (reroute_r == 8'hFF) ? reroute_r : reroute_r + 8'd1;
                end else if ((mode_r == MODE_RR) && (wait_r != WAIT_LAST)) begin
                    wait_s      = wait_r + 8'd1;
                end else begin
                    wait_s      = wait_r;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                out_valid_s = 8'h00;
            end
        endcase
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign out_data    = data_r;
    assign cur_tgt     = tgt_r;
    assign busy        = (state_r == ST_SEND);
    assign xfer_cnt    = xfer_r;
    assign reroute_cnt = reroute_r;

endmodule

// File: tb/tb_demux_rr_scheduler.sv
// Directed bench for demux_rr_scheduler: a behavioural reference model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_demux_rr_scheduler;

    localparam int TO = 4;

    logic        clk;
    logic        rst;
    logic        mode;
    logic [2:0]  sel;
    logic [7:0]  en_mask;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [7:0]  out_valid;
    logic [7:0]  out_data;
    logic [7:0]  out_ready;
    logic [2:0]  cur_tgt;
    logic        busy;
    logic [15:0] xfer_cnt;
    logic [7:0]  reroute_cnt;

    int n_tests;
    int n_fail;
    bit check_en;

    demux_rr_scheduler #(.DW(8), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .sel         (sel),
        .en_mask     (en_mask),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .cur_tgt     (cur_tgt),
        .busy        (busy),
        .xfer_cnt    (xfer_cnt),
        .reroute_cnt (reroute_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state, expressed in channel numbers and plain counts.
    bit        m_busy, m_ready, m_mode;
    int        m_tgt, m_ptr, m_wait, m_xfer, m_rr;
    logic [7:0] m_data;

    // First enabled channel at or after 'start' going upward modulo 8, or -1.
    function automatic int next_en(input logic [7:0] m, input int start);
        for (int k = 0; k < 8; k++) begin
            if (m[(start + k) % 8]) return (start + k) % 8;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0; m_ready <= 1'b0; m_mode <= 1'b0; m_tgt <= 0; m_ptr <= 0;
            m_wait <= 0; m_xfer <= 0; m_rr <= 0; m_data <= 8'h00;
        end else if (!m_busy) begin
            if (in_valid && m_ready) begin
                m_busy  <= 1'b1;
                m_ready <= 1'b0;
                m_mode  <= mode;
                m_data  <= in_data;
                m_wait  <= 0;
                m_tgt   <= mode ? int'(sel)
                         : (next_en(en_mask, m_ptr) >= 0 ? next_en(en_mask, m_ptr) : m_ptr);
            end else begin
                m_ready <= mode || (en_mask != 8'h00);
            end
        end else if (out_ready[m_tgt]) begin
            m_busy  <= 1'b0;
            m_ready <= mode || (en_mask != 8'h00);
            m_xfer  <= (m_xfer + 1) % 65536;
            if (!m_mode) m_ptr <= (m_tgt + 1) % 8;
        end else if (!m_mode) begin
            if ((m_wait == TO - 1 || !en_mask[m_tgt])
                && next_en(en_mask & ~(8'd1 << m_tgt), (m_tgt + 1) % 8) >= 0) begin
                m_tgt  <= next_en(en_mask & ~(8'd1 << m_tgt), (m_tgt + 1) % 8);
                m_wait <= 0;
                m_rr   <= (m_rr == 255) ? 255 : m_rr + 1;
            end else if (m_wait < TO - 1) begin
                m_wait <= m_wait + 1;
            end
        end
    end

    task automatic compare_model();
        logic [7:0] exp_ov;
        exp_ov = m_busy ? (8'd1 << m_tgt) : 8'h00;
        n_tests++;
        if (in_ready !== m_ready || out_valid !== exp_ov || out_data !== m_data ||
            cur_tgt !== 3'(m_tgt) || busy !== m_busy || xfer_cnt !== 16'(m_xfer) ||
            reroute_cnt !== 8'(m_rr)) begin
            n_fail++;
            $display("FAIL model_cycle t=%0t: got rdy=%b ov=%h d=%h tgt=%0d busy=%b xfer=%0d rr=%0d, need rdy=%b ov=%h d=%h tgt=%0d busy=%b xfer=%0d rr=%0d",
                     $time, in_ready, out_valid, out_data, cur_tgt, busy, xfer_cnt, reroute_cnt,
                     m_ready, exp_ov, m_data, m_tgt, m_busy, m_xfer, m_rr);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (check_en) compare_model();
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, need %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input int exp_ch);
        int g;
        g = 0;
        while (!in_ready && g < 50) begin
            tick();
            g++;
        end
        check("ready_wait", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        check("accept_ch", 64'(out_valid), 64'(8'd1 << exp_ch));
        check("accept_data", 64'(out_data), 64'(d));
    endtask

    task automatic wait_done();
        int g;
        g = 0;
        while (busy && g < 50) begin
            tick();
            g++;
        end
        check("done", 64'(busy), 64'd0);
    endtask

    initial begin
        int n;
        logic [7:0] sparse_seq [4];
        sparse_seq = '{8'd2, 8'd5, 8'd7, 8'd2};
        n_tests = 0; n_fail = 0; check_en = 1'b0;
        rst = 1'b1; mode = 1'b0; sel = 3'd0; en_mask = 8'hFF;
        in_valid = 1'b0; in_data = 8'h00; out_ready = 8'hFF;
        tick();
        check_en = 1'b1;
        tick();
        check("reset_state", {27'd0, in_ready, out_valid, busy, cur_tgt, xfer_cnt, reroute_cnt}, 64'd0);
        rst = 1'b0;
        tick();

        // Round-robin sweep over all channels
        for (int i = 0; i < 8; i++) begin
            send(8'h10 + 8'(i), i);
            wait_done();
        end
        check("sweep_xfer", 64'(xfer_cnt), 64'd8);

        // Sparse mask with pointer wrap
        en_mask = 8'b1010_0100;
        for (int i = 0; i < 4; i++) begin
            send(8'h20 + 8'(i), int'(sparse_seq[i]));
            wait_done();
        end
        check("sparse_xfer", 64'(xfer_cnt), 64'd12);

        // Fixed select held off far past the timeout
        mode = 1'b1; sel = 3'd6; out_ready = 8'h00;
        send(8'hA5, 6);
        for (int i = 0; i < 20; i++) tick();
        check("fix_hold_ov", 64'(out_valid), 64'h40);
        check("fix_hold_data", 64'(out_data), 64'hA5);
        check("fix_no_reroute", 64'(reroute_cnt), 64'd0);
        out_ready = 8'h40;
        tick();
        check("fix_done", {47'd0, busy, cur_tgt, xfer_cnt}, {47'd0, 1'b0, 3'd6, 16'd13});
        mode = 1'b0;

        // Timeout reroute from channel 0 to channel 1
        en_mask = 8'h03; out_ready = 8'h00;
        tick();
        out_ready = 8'h02;
        send(8'h3C, 0);
        n = 0;
        while (out_valid == 8'h01 && n < 50) begin
            n++;
            tick();
        end
        check("timeout_hold_cycles", 64'(n), 64'd4);
        check("timeout_new_ch", 64'(out_valid), 64'h02);
        check("timeout_rr_cnt", 64'(reroute_cnt), 64'd1);
        wait_done();
        check("timeout_xfer", 64'(xfer_cnt), 64'd14);

        // Completion on the same edge the timeout would fire
        out_ready = 8'h00;
        send(8'h5A, 0);
        tick(); tick(); tick();
        out_ready = 8'h01;
        tick();
        check("tie_done", {47'd0, busy, cur_tgt, xfer_cnt}, {47'd0, 1'b0, 3'd0, 16'd15});
        check("tie_no_reroute", 64'(reroute_cnt), 64'd1);

        // Target dropped from the mask mid-transfer
        en_mask = 8'h0C; out_ready = 8'h00;
        send(8'hC3, 2);
        en_mask = 8'h08;
        tick();
        check("maskdrop_ch", 64'(out_valid), 64'h08);
        check("maskdrop_rr_cnt", 64'(reroute_cnt), 64'd2);
        out_ready = 8'h08;
        tick();
        check("maskdrop_xfer", {47'd0, busy, xfer_cnt}, {47'd0, 1'b0, 16'd16});

        // Empty mask blocks acceptance
        en_mask = 8'h00;
        tick();
        in_valid = 1'b1;
        tick(); tick(); tick();
        check("empty_mask", {62'd0, in_ready, busy}, 64'd0);
        in_valid = 1'b0;

        // Reset in the middle of a transfer, then resume from channel 0
        en_mask = 8'hFF; out_ready = 8'h00;
        send(8'h77, 4);
        tick(); tick();
        rst = 1'b1;
        tick();
        check("midrst_state", {27'd0, in_ready, out_valid, busy, cur_tgt, xfer_cnt, reroute_cnt}, 64'd0);
        rst = 1'b0;
        out_ready = 8'hFF;
        send(8'h99, 0);
        wait_done();
        check("resume_xfer", 64'(xfer_cnt), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_rr_scheduler.md
Name: demux_rr_scheduler

Overview:
- Sequencing controller in front of the 1-to-8 demultiplexer.
- Accepts one data word at a time on a valid/ready input and routes it to exactly one of 8 destination channels.
- Destination is chosen either round-robin over an enable mask or by a fixed 3-bit select.
- Owns the per-channel valid/ready handshake and timeout-driven rerouting; the select it produces is what drives the demux select lines.

Parameters:
- DW, 8, data word width.
- TIMEOUT, 15, cycles a round-robin transfer waits on a non-ready channel before rerouting (range 1..255).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset; synchronous, active-high.
- mode  input  1  0 = round-robin, 1 = fixed select.
- sel  input  3  fixed-mode destination; sampled only at accept.
- en_mask  input  8  channel enables, round-robin mode only.
- in_valid  input  1  input word valid.
- in_data  input  DW  input word.
- in_ready  output  1  scheduler can accept.
- out_valid  output  8  one-hot channel valid.
- out_data  output  DW  held word, broadcast to all channels.
- out_ready  input  8  per-channel ready.
- cur_tgt  output  3  current/last target index.
- busy  output  1  high in SEND.
- xfer_cnt  output  16  completed transfers, wraps.
- reroute_cnt  output  8  timeout reroutes, saturates at 255.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_data=0, cur_tgt=0, busy=0, xfer_cnt=0, reroute_cnt=0, rr pointer ptr=0, wait_cnt=0, state=IDLE.
- All outputs are registered.
- FSM has two states, IDLE and SEND.
- IDLE:
  - in_ready=1 iff mode=1, or mode=0 and en_mask!=0.
  - A transfer is accepted on a clock edge where in_valid & in_ready.
  - On accept: data_q<=in_data.
  - Target: mode=1 gives tgt=sel. mode=0 gives tgt=first set bit of en_mask searching upward from ptr with wrap (7 wraps to 0).
  - On accept: wait_cnt<=0, state<=SEND.
- SEND:
  - in_ready=0, busy=1, out_valid=one-hot(tgt), out_data=data_q, cur_tgt=tgt.
  - Latency: a word accepted at edge k shows out_valid from cycle k+1.
  - Completion occurs at the first edge with out_ready[tgt]=1. On completion: xfer_cnt++, ptr<=(tgt+1) mod 8 in mode 0 (ptr unchanged in mode 1), out_valid<=0, state<=IDLE.
  - Peak throughput is one word per 2 cycles.
- Readiness of non-target channels is ignored; out_valid is never more than one-hot.
- Timeout (mode=0 only):
  - wait_cnt increments each SEND cycle without completion.
  - When wait_cnt==TIMEOUT-1 and another enabled channel exists, tgt<=next enabled after tgt (wrap), wait_cnt<=0, reroute_cnt++ (saturating). The same data_q is kept.
  - If tgt is the only enabled channel, the transfer keeps waiting and wait_cnt holds.
- Mask change during SEND, mode=0: if en_mask[tgt] drops to 0, reroute next cycle as for a timeout (counts as a reroute). If en_mask becomes 0, out_valid stays on the old tgt until it completes.
- Mode or sel change during SEND has no effect on the in-flight word; mode is re-evaluated in IDLE.
- Simultaneous completion and timeout on the same edge: completion wins, no reroute.
- Reset mid-SEND: the held word is dropped and all registers return to reset values on that edge.
- No data is ever duplicated; each accepted word completes exactly once.

Decomposition:
- Shared package/header demux_pkg holds:
  - CH_NUM=8, CH_W=3.
  - State encodings ST_IDLE=1'b0, ST_SEND=1'b1.
  - MODE_RR=0, MODE_FIX=1.
- One combinational sub-module, rr_next_finder:
  - Inputs: mask[7:0], start[2:0].
  - Outputs: idx[2:0], found.
  - Used for both the accept search (start=ptr) and the reroute search (start=tgt+1).

Test Plan:
- Round-robin sweep: mode=0, en_mask=8'hFF, out_ready=8'hFF, 8 back-to-back words 0x10..0x17 → channels 0..7 in order, each out_valid one cycle after accept, xfer_cnt=8.
- Sparse mask: en_mask=8'b1010_0100, 4 words → targets 2,5,7,2; ptr wraps correctly.
- Fixed mode: mode=1, sel=3'd6, word 0xA5, out_ready[6] delayed 5 cycles → out_valid=8'h40 held 5 cycles with out_data=0xA5, no reroute even after 20 cycles if held off.
- Timeout: mode=0, TIMEOUT=4, en_mask=8'h03, out_ready=8'h02, word 0x3C → out_valid=8'h01 for 4 cycles, then 8'h02, completes, reroute_cnt=1, xfer_cnt=1.
- Edge cases:
  - en_mask=0 in mode 0 → in_ready=0.
  - Completion on the same edge as the timeout → no reroute.
  - rst asserted mid-SEND → next cycle out_valid=0, counters=0.
  - Resumed traffic then starts at channel 0.
